// File: rtl/seven_seg_pkg.sv
// Segment pattern constants (a..g, a is MSB) shared by the scan decoder and its pattern lookup.
package seven_seg_pkg;
   localparam int w_seg = 7;

   localparam logic [w_seg-1:0] seg_0     = 7'b1111110;
   localparam logic [w_seg-1:0] seg_1     = 7'b0110000;
   localparam logic [w_seg-1:0] seg_2     = 7'b1101101;
   localparam logic [w_seg-1:0] seg_3     = 7'b1111001;
   localparam logic [w_seg-1:0] seg_4     = 7'b0110011;
   localparam logic [w_seg-1:0] seg_5     = 7'b1011011;
   localparam logic [w_seg-1:0] seg_6     = 7'b1011111;
   localparam logic [w_seg-1:0] seg_7     = 7'b1110000;
   localparam logic [w_seg-1:0] seg_8     = 7'b1111111;
   localparam logic [w_seg-1:0] seg_9     = 7'b1111011;
   localparam logic [w_seg-1:0] seg_a     = 7'b1110111;
   localparam logic [w_seg-1:0] seg_b     = 7'b0011111;
   localparam logic [w_seg-1:0] seg_c     = 7'b1001110;
   localparam logic [w_seg-1:0] seg_d     = 7'b0111101;
   localparam logic [w_seg-1:0] seg_e     = 7'b1001111;
   localparam logic [w_seg-1:0] seg_f     = 7'b1000111;
   localparam logic [w_seg-1:0] seg_blank = 7'b0000000;
endpackage

// File: rtl/seven_seg_pattern_to_hex.sv
// Combinational a..g pattern to hex nibble lookup; a blank pattern is reported separately
// and is not counted as a recognised digit.
module seven_seg_pattern_to_hex
   import seven_seg_pkg::*;
(
   input  logic [w_seg-1:0] seg,
   output logic [3:0]       nibble,
   output logic             valid,
   output logic             is_blank
);

   always_comb begin
      nibble   = 4'h0;
      valid    = 1'b1;
      is_blank = 1'b0;
      case (seg)
         seg_0:     nibble = 4'h0;
         seg_1:     nibble = 4'h1;
         seg_2:     nibble = 4'h2;
         seg_3:     nibble = 4'h3;
         seg_4:     nibble = 4'h4;
         seg_5:     nibble = 4'h5;
         seg_6:     nibble = 4'h6;
         seg_7:     nibble = 4'h7;
         seg_8:     nibble = 4'h8;
         seg_9:     nibble = 4'h9;
         seg_a:     nibble = 4'ha;
         seg_b:     nibble = 4'hb;
         seg_c:     nibble = 4'hc;
         seg_d:     nibble = 4'hd;
         seg_e:     nibble = 4'he;
         seg_f:     nibble = 4'hf;
         seg_blank: begin
            valid    = 1'b0;
            is_blank = 1'b1;
         end
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Samples a scanned seven-segment bus, captures each digit once it has been stable, and flags full frames.
// SEVEN_SEG_SCAN_DECODER_ACTIVE_LOW_EN inverts segment and strobe inputs for common-anode boards.
module seven_seg_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int w_digit       = 8,
   parameter int stable_cycles = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             abcdefgh,
   input  logic [w_digit-1:0]     digit,
   output logic [4*w_digit-1:0]   hex,
   output logic [w_digit-1:0]     dp,
   output logic [w_digit-1:0]     blank,
   output logic [w_digit-1:0]     seen,
   output logic                   frame_done,
   output logic                   error
);

   localparam logic [7:0] c_cnt_max = 8'(stable_cycles);
   localparam logic [7:0] c_cnt_cap = 8'(stable_cycles - 1);

   logic [7:0]           w_seg_in;
   logic [w_digit-1:0]   w_dig_in;

`ifdef SEVEN_SEG_SCAN_DECODER_ACTIVE_LOW_EN
   assign w_seg_in = ~abcdefgh;
   assign w_dig_in = ~digit;
`else
   assign w_seg_in = abcdefgh;
   assign w_dig_in = digit;
`endif

   logic [7:0]           r_seg_q;
   logic [w_digit-1:0]   r_dig_q;
   logic [7:0]           r_cnt;
   logic [4*w_digit-1:0] r_hex;
   logic [w_digit-1:0]   r_dp;
   logic [w_digit-1:0]   r_blank;
   logic [w_digit-1:0]   r_seen;
   logic                 r_frame_done;
   logic                 r_error;

   logic [3:0]           w_nibble;
   logic                 w_valid;
   logic                 w_is_blank;

   seven_seg_pattern_to_hex u_pattern (
      .seg      (r_seg_q[7:1]),
      .nibble   (w_nibble),
      .valid    (w_valid),
      .is_blank (w_is_blank)
   );

   // The counter is cleared whenever the sampled bus moves, so reaching the
   // threshold already implies an unbroken run of identical samples.
   logic w_changed, w_capture, w_good, w_update, w_err, w_seen_full;
   assign w_changed   = (w_seg_in != r_seg_q) || (w_dig_in != r_dig_q);
   assign w_capture   = (r_cnt == c_cnt_cap) && (r_dig_q != '0);
   assign w_good      = $onehot(r_dig_q) && (w_valid || w_is_blank);
   assign w_update    = w_capture && w_good;
   assign w_err       = w_capture && !w_good;
   assign w_seen_full = &r_seen;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_seg_q      <= '0;
         r_dig_q      <= '0;
         r_cnt        <= '0;
         r_hex        <= '0;
         r_dp         <= '0;
         r_blank      <= '0;
         r_seen       <= '0;
         r_frame_done <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_seg_q <= w_seg_in;
         r_dig_q <= w_dig_in;
         if (w_changed)
            r_cnt <= '0;
         else if (r_cnt != c_cnt_max)
            r_cnt <= r_cnt + 8'd1;

         r_error      <= w_err;
         r_frame_done <= w_seen_full;
         r_seen       <= (w_seen_full ? '0 : r_seen) | (w_update ? r_dig_q : '0);

         for (int i = 0; i < w_digit; i++) begin
            if (w_update && r_dig_q[i]) begin
               r_hex[4*i +: 4] <= w_nibble;
               r_dp[i]         <= r_seg_q[0];
               r_blank[i]      <= w_is_blank;
            end
         end
      end
   end

   assign hex        = r_hex;
   assign dp         = r_dp;
   assign blank      = r_blank;
   assign seen       = r_seen;
   assign frame_done = r_frame_done;
   assign error      = r_error;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: stimulus queues expected capture/error/frame events, a negedge monitor checks them.
module tb_seven_seg_scan_decoder;
   localparam int W = 8;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    abcdefgh = '0;
   logic [W-1:0]  digit = '0;
   logic [4*W-1:0] hex;
   logic [W-1:0]  dp, blank, seen;
   logic          frame_done, error;

   seven_seg_scan_decoder #(.w_digit(W), .stable_cycles(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abcdefgh   (abcdefgh),
      .digit      (digit),
      .hex        (hex),
      .dp         (dp),
      .blank      (blank),
      .seen       (seen),
      .frame_done (frame_done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   typedef struct {
      logic        err;
      logic        frm;
      int          at;
      logic [31:0] hex;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic [7:0]  seen;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference state, updated by hand from the directed vectors
   logic [31:0] m_hex = '0;
   logic [7:0]  m_dp = '0, m_blank = '0, m_seen = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: any pulse or change of captured state is an event to be matched
   logic [55:0] prev_state = '0;
   exp_t        mon_e;
   always @(negedge clk) begin
      if (rst_q && (error || frame_done || {hex, dp, blank, seen} != prev_state)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got err=%0b frame=%0b hex=%0h seen=%0h, required no event (cycle %0d)",
                     error, frame_done, hex, seen, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("event_cycle", 64'(cyc), 64'(mon_e.at));
            chk("error",      64'(error), 64'(mon_e.err));
            chk("frame_done", 64'(frame_done), 64'(mon_e.frm));
            chk("hex",        64'(hex), 64'(mon_e.hex));
            chk("dp",         64'(dp), 64'(mon_e.dp));
            chk("blank",      64'(blank), 64'(mon_e.blank));
            chk("seen",       64'(seen), 64'(mon_e.seen));
         end
      end
      prev_state = {hex, dp, blank, seen};
   end

   task automatic push(input logic err, input logic frm, input int at);
      exp_t e;
      e.err = err; e.frm = frm; e.at = at;
      e.hex = m_hex; e.dp = m_dp; e.blank = m_blank; e.seen = m_seen;
      q.push_back(e);
   endtask

   task automatic hold(input logic [7:0] seg, input logic [7:0] dg, input int n);
      abcdefgh = seg;
      digit    = dg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Valid capture at pos; nib/bl are the hand-decoded expectation for seg
   task automatic scan(input int pos, input logic [7:0] seg, input logic [3:0] nib,
                       input logic bl, input int n);
      int t0;
      t0 = cyc;
      m_hex[4*pos +: 4] = nib;
      m_dp[pos]    = seg[0];
      m_blank[pos] = bl;
      m_seen[pos]  = 1'b1;
      push(1'b0, 1'b0, t0 + 1 + S);
      if (m_seen == 8'hFF) begin
         m_seen = '0;
         push(1'b0, 1'b1, t0 + 2 + S);
      end
      hold(seg, 8'(1 << pos), n);
   endtask

   task automatic bad(input logic [7:0] seg, input logic [7:0] dg, input int n);
      int t0;
      t0 = cyc;
      push(1'b1, 1'b0, t0 + 1 + S);
      hold(seg, dg, n);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hex"},   64'(hex), 64'd0);
      chk({tag, "_dp"},    64'(dp), 64'd0);
      chk({tag, "_blank"}, 64'(blank), 64'd0);
      chk({tag, "_seen"},  64'(seen), 64'd0);
      chk({tag, "_pulse"}, 64'({frame_done, error}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random bus activity
      for (int i = 0; i < 3; i++) begin
         abcdefgh = 8'($urandom);
         digit    = 8'($urandom);
         @(posedge clk);
         #1;
         chk_zero("reset");
      end
      abcdefgh = '0;
      digit    = '0;
      rst_n    = 1'b1;
      hold(8'h00, 8'h00, 4);

      // Full frame: 1..8 on digits 0..7
      scan(0, 8'h60, 4'h1, 1'b0, 6);
      scan(1, 8'hDA, 4'h2, 1'b0, 6);
      scan(2, 8'hF2, 4'h3, 1'b0, 6);
      scan(3, 8'h66, 4'h4, 1'b0, 6);
      scan(4, 8'hB6, 4'h5, 1'b0, 6);
      scan(5, 8'hBE, 4'h6, 1'b0, 6);
      scan(6, 8'hE0, 4'h7, 1'b0, 6);
      scan(7, 8'hFE, 4'h8, 1'b0, 6);
      chk("frame_hex", 64'(hex), 64'h87654321);

      // Glitch shorter than the stability window, then exactly S samples
      hold(8'hFE, 8'h04, 2);
      scan(2, 8'h60, 4'h1, 1'b0, 4);

      // Errors: two strobes at once, then an unknown pattern
      bad(8'h60, 8'h03, 5);
      bad(8'h02, 8'h01, 5);

      // Blank with dp, then overwrite with 8.
      scan(5, 8'h01, 4'h0, 1'b1, 6);
      scan(5, 8'hFF, 4'h8, 1'b0, 6);

      // Partial frame, reset, then a full post-reset frame
      scan(0, 8'hFC, 4'h0, 1'b0, 6);
      scan(1, 8'h60, 4'h1, 1'b0, 6);
      scan(2, 8'hDA, 4'h2, 1'b0, 6);
      scan(3, 8'hF2, 4'h3, 1'b0, 6);
      rst_n    = 1'b0;
      abcdefgh = '0;
      digit    = '0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_hex   = '0;
      m_dp    = '0;
      m_blank = '0;
      m_seen  = '0;
      chk_zero("midreset");
      hold(8'h00, 8'h00, 2);
      scan(0, 8'h8E, 4'hF, 1'b0, 6);
      scan(1, 8'h9E, 4'hE, 1'b0, 6);
      scan(2, 8'h7A, 4'hD, 1'b0, 6);
      scan(3, 8'h9C, 4'hC, 1'b0, 6);
      scan(4, 8'h3E, 4'hB, 1'b0, 6);
      scan(5, 8'hEE, 4'hA, 1'b0, 6);
      scan(6, 8'hF6, 4'h9, 1'b0, 6);
      scan(7, 8'hFC, 4'h0, 1'b0, 6);
      chk("final_hex", 64'(hex), 64'h09ABCDEF);

      hold(8'h00, 8'h00, 2);
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d events still pending, required 0", q.size());
      end
      hold(8'h00, 8'h00, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receiving end of the multiplexed seven-segment display bus (`abcdefgh` plus one-hot `digit`). It samples the scanned bus and waits for each digit strobe to settle. It then decodes the segment pattern back to a hex nibble per digit position and flags each completed scan frame. It is used as an on-chip loopback monitor of `lab_top` display output and as a reusable checker in benches.

## Interface

Parameters:
- `w_digit`, default 8: number of digit positions, equal to the width of `digit`.
- `stable_cycles`, default 4: consecutive identical samples required before a capture. Legal range is 1 to 255.

Ports:
- `clk`  input  1: clock.
- `rst_n`  input  1: reset, synchronous, active-low.
- `abcdefgh`  input  8: segment bus. Bit 7 is segment a, bit 1 is segment g, bit 0 is dp (h). Active-high.
- `digit`  input  `w_digit`: digit strobe, one-hot, active-high.
- `hex`  output  `4*w_digit`: decoded nibble per position. Position i occupies bits [4i+3:4i].
- `dp`  output  `w_digit`: captured dp bit per position.
- `blank`  output  `w_digit`: last capture at this position had all of a–g off.
- `seen`  output  `w_digit`: positions captured since the last frame boundary.
- `frame_done`  output  1: one-cycle pulse when every position has been captured.
- `error`  output  1: one-cycle pulse on an unrecognised pattern or a non-one-hot strobe.

## Operation

- **Input stage:** `abcdefgh` and `digit` are registered together as `s_q`, 1 cycle.
- **Stability counter `cnt`** (8 bits):
  - Cleared to 0 when `s_q` changes value.
  - Otherwise increments, saturating at `stable_cycles`.
- **Capture event:** occurs when `cnt == stable_cycles-1`, `s_q` is unchanged, and the registered `digit` is non-zero. It fires exactly once per stable window.
- **Strobe check at capture:**
  - `digit == 0`: idle. No capture, no error.
  - More than one bit set: `error` pulse, no state update.
- **Segment decode** of a–g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Recognised pattern: `hex[i]` takes the nibble, `dp[i]` takes bit 0, `blank[i]` is cleared, `seen[i]` is set.
  - a–g all zero: `hex[i]` = 0, `blank[i]` = 1, `dp[i]` is latched, `seen[i]` is set.
  - Any other pattern: `error` pulse, position i unchanged.
- **Frame:**
  - When `seen` becomes all ones, `frame_done` pulses on the next cycle and `seen` clears to 0 in that same cycle.
  - A capture in the clearing cycle sets its bit in the fresh `seen`.
- **Re-captures:** a repeated capture at an already-seen position overwrites its `hex`, `dp` and `blank` and keeps its `seen` bit.

## Timing

- **Reset values:** all outputs are 0, and `s_q` and `cnt` are 0.
- **Reset mid-scan:** discards all captured data. No `frame_done` or `error` is pulsed in the cycle after reset is released.
- **Capture latency:** inputs changed before edge k and then held are registered at edge k. `hex`, `dp`, `blank` and `seen` update at edge k+`stable_cycles`. `error` pulses in the same cycle.
- **Frame latency:** `frame_done` asserts 1 cycle after the capture that completes `seen`.
- **Glitch rejection:** an input change shorter than `stable_cycles` consecutive samples produces no capture.
- **Non-changing bus:** a bus that never changes captures once, then stays idle until `s_q` changes.

## Configuration

- Macro `SEVEN_SEG_SCAN_DECODER_ACTIVE_LOW_EN`.
- **Defined:** `abcdefgh` and `digit` are inverted before the input register, for common-anode boards. All decode rules then apply to the inverted values.
- **Undefined:** no inversion, and there is no extra logic.

## Structure

- **Package `seven_seg_pkg`:**
  - The 16 seven-bit segment pattern constants (`seg_0` … `seg_f`).
  - `seg_blank`.
  - A `w_seg` = 7 constant.
- **Sub-module `seven_seg_pattern_to_hex`:** combinational. Takes 7 bits in and produces `nibble[3:0]`, `valid` and `is_blank`. One instance is shared by all positions.
- **Top:** input register, counter, one-hot check, per-position register array and frame logic.

## Test plan

1. **Reset:** hold `rst_n`=0 for 3 cycles with random inputs. All outputs must be 0. Release; no pulse appears.
2. **Full frame:** `stable_cycles`=4 and `w_digit`=8. Scan digits 0–7 showing the patterns for 1,2,3,4,5,6,7,8 with dp off, 6 cycles each.
   - `hex` must equal 0x87654321.
   - `frame_done` pulses exactly once, 1 cycle after digit 7 is captured.
   - `seen` then returns to 0.
3. **Glitch:** set `digit`=0x04 and `abcdefgh`=0xFE. Hold for 2 cycles, then change to 0x60.
   - The 0xFE sample is not captured.
   - Holding 0x60 for 4 cycles gives `hex[2]`=1.
4. **Errors:**
   - `digit`=0x03 held for 5 cycles gives a single `error` pulse and no output changes.
   - `abcdefgh`=0x02 on digit 0 gives `error` and leaves `hex[0]` unchanged.
5. **Blank and dp:** `abcdefgh`=0x01 on digit 5 gives `blank[5]`=1, `dp[5]`=1 and `hex[5]`=0. A later 0xFF on digit 5 gives `hex[5]`=8, `dp[5]`=1 and `blank[5]`=0.
6. **Mid-frame reset:** capture digits 0–3, pulse `rst_n` low for 1 cycle, then scan all 8. `frame_done` must fire only after all 8 post-reset captures.
